// File: rtl/module_bcd_adder_if.sv
// Start/done handshake and operand/result bundle for the serial BCD adder.
// With BCD_SUB_EN defined the bundle also carries sub (request) and neg (result sign).
interface module_bcd_adder_if #(parameter int NDIG = 3);
   logic                start;
   logic [4*NDIG-1:0]   first_num;
   logic [4*NDIG-1:0]   second_num;
   logic [4*NDIG+3:0]   sum_bcd;
   logic                busy;
   logic                done;
   logic                err;
`ifdef BCD_SUB_EN
   logic                sub;
   logic                neg;

   modport master (output start, first_num, second_num, sub,
                   input  sum_bcd, busy, done, err, neg);
   modport slave  (input  start, first_num, second_num, sub,
                   output sum_bcd, busy, done, err, neg);
`else
   modport master (output start, first_num, second_num,
                   input  sum_bcd, busy, done, err);
   modport slave  (input  start, first_num, second_num,
                   output sum_bcd, busy, done, err);
`endif
endinterface

// File: rtl/module_bcd_adder.sv
// Serial packed-BCD adder: one digit per clock, NDIG+1 digit result, start/done handshake.
// Optional macro BCD_SUB_EN adds a magnitude-subtract mode (sub in, neg out).
//
// state | meaning
// IDLE  | waiting for start; result and flags held
// ADD   | processing digit idx, carry/borrow rippling upward
// FIN   | write top digit (or zero result on err), pulse done
module module_bcd_adder #(
   parameter int NDIG = 3
) (
   input  logic              clk,
   input  logic              rst,
   module_bcd_adder_if.slave bus
);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, FIN = 2'd2} state_t;

   state_t              state;
   logic [4*NDIG-1:0]   a_q;
   logic [4*NDIG-1:0]   b_q;
   logic [IW-1:0]       idx;
   logic                carry;
   logic [4*NDIG+3:0]   sum_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
`ifdef BCD_SUB_EN
   logic                sub_q;
   logic                neg_q;
`endif

   logic [4*NDIG-1:0]   a_sh;
   logic [4*NDIG-1:0]   b_sh;
   logic [3:0]          a_dig;
   logic [3:0]          b_dig;
   logic [4:0]          s;
   logic [3:0]          dig_nxt;
   logic                carry_nxt;

   function automatic logic has_bad(input logic [4*NDIG-1:0] v);
      has_bad = 1'b0;
      for (int i = 0; i < NDIG; i++)
         if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
   endfunction

   always_comb begin
      a_sh      = a_q >> {idx, 2'b00};
      b_sh      = b_q >> {idx, 2'b00};
      a_dig     = a_sh[3:0];
      b_dig     = b_sh[3:0];
      s         = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry};
      dig_nxt   = s[3:0];
      carry_nxt = 1'b0;
`ifdef BCD_SUB_EN
      if (sub_q) begin
         // 5-bit two's complement: bit 4 set means the digit went negative
         s = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, carry};
         dig_nxt = s[3:0];
         if (s[4]) begin
            dig_nxt   = s[3:0] + 4'd10;
            carry_nxt = 1'b1;
         end
      end else
`endif
      if (s > 5'd9) begin
         dig_nxt   = s[3:0] + 4'd6;
         carry_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
`ifdef BCD_SUB_EN
         sub_q  <= 1'b0;
         neg_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         busy_q <= (state != IDLE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q   <= bus.first_num;
                  b_q   <= bus.second_num;
                  sum_q <= '0;
                  carry <= 1'b0;
                  idx   <= '0;
                  err_q <= has_bad(bus.first_num) | has_bad(bus.second_num);
`ifdef BCD_SUB_EN
                  sub_q <= bus.sub;
                  neg_q <= 1'b0;
                  // Subtract the smaller from the larger so the result is a magnitude
                  if (bus.sub && (bus.second_num > bus.first_num)) begin
                     a_q   <= bus.second_num;
                     b_q   <= bus.first_num;
                     neg_q <= 1'b1;
                  end
`endif
                  state <= ADD;
               end
            end
            ADD: begin
               for (int i = 0; i < NDIG; i++)
                  if (idx == IW'(i)) sum_q[4*i +: 4] <= dig_nxt;
               carry <= carry_nxt;
               if (idx == IW'(NDIG - 1)) state <= FIN;
               else                      idx   <= idx + IW'(1);
            end
            FIN: begin
               if (err_q)
                  sum_q <= '0;
               else
`ifdef BCD_SUB_EN
                  sum_q[4*NDIG +: 4] <= sub_q ? 4'd0 : {3'b000, carry};
`else
                  sum_q[4*NDIG +: 4] <= {3'b000, carry};
`endif
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sum_bcd = sum_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;
`ifdef BCD_SUB_EN
   assign bus.neg     = neg_q;
`endif
endmodule

// File: tb/tb_module_bcd_adder.sv
// Self-checking bench for module_bcd_adder: decimal-arithmetic reference model checked every
// cycle, plus directed cases with literal expectations (BCD_SUB_EN cases when defined).
`timescale 1ns/1ps
module tb_module_bcd_adder;
   localparam int NDIG = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   module_bcd_adder_if #(.NDIG(NDIG)) bus();
   module_bcd_adder #(.NDIG(NDIG)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bcd2int(input logic [4*NDIG-1:0] v);
      int r = 0;
      for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [4*NDIG+3:0] int2bcd(input int v);
      logic [4*NDIG+3:0] r = '0;
      int t = v;
      for (int i = 0; i <= NDIG; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic bad(input logic [4*NDIG-1:0] v);
      for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [4*NDIG-1:0] rnd_bcd();
      logic [4*NDIG-1:0] r;
      for (int i = 0; i < NDIG; i++)
         r[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      return r;
   endfunction

   // Reference model: operation timeline as a countdown plus decimal arithmetic on latched operands
   int                rem = 0;
   logic [4*NDIG+3:0] exp_sum = '0;
   logic              exp_err = 1'b0;
   logic              exp_neg = 1'b0;
   logic              exp_busy = 1'b0;
   logic              exp_done = 1'b0;
   logic              have_res = 1'b1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem = 0; exp_sum = '0; exp_err = 1'b0; exp_neg = 1'b0;
         exp_busy = 1'b0; exp_done = 1'b0; have_res = 1'b1;
      end else begin
         logic [4*NDIG-1:0] a, b, t;
         int r;
         exp_done = 1'b0;
         exp_busy = (rem > 0);
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin exp_done = 1'b1; have_res = 1'b1; end
         end else if (bus.start) begin
            a = bus.first_num;
            b = bus.second_num;
            exp_err = bad(a) | bad(b);
            exp_neg = 1'b0;
            r = bcd2int(a) + bcd2int(b);
`ifdef BCD_SUB_EN
            if (bus.sub) begin
               if (b > a) begin t = a; a = b; b = t; exp_neg = 1'b1; end
               r = bcd2int(a) - bcd2int(b);
            end
`endif
            exp_sum  = exp_err ? '0 : int2bcd(r);
            have_res = 1'b0;
            rem      = NDIG + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("done", 32'(bus.done), 32'(exp_done));
         chk("busy", 32'(bus.busy), 32'(exp_busy));
         if (have_res) begin
            chk("sum", 32'(bus.sum_bcd), 32'(exp_sum));
            chk("err", 32'(bus.err), 32'(exp_err));
`ifdef BCD_SUB_EN
            chk("neg", 32'(bus.neg), 32'(exp_neg));
`endif
         end
      end
   end

   task automatic set_sub(input logic s);
`ifdef BCD_SUB_EN
      bus.sub = s;
`else
      if (s) $display("sub request ignored in add-only build");
`endif
   endtask

   // One operation with a spurious start pulse and operand change mid-operation
   task automatic run_op(input string nm, input logic [4*NDIG-1:0] a, input logic [4*NDIG-1:0] b,
                         input logic s, input logic [4*NDIG+3:0] xs, input logic xe, input logic xn);
      int  n = 0;
      int  nb = 0;
      bit  seen = 1'b0;
      @(negedge clk);
      bus.first_num = a; bus.second_num = b; set_sub(s); bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 1; i <= 12 && !seen; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus.start = 1'b1; bus.first_num = ~a; bus.second_num = ~b;
         end
         if (i == 2) bus.start = 1'b0;
         if (bus.busy) nb++;
         if (bus.done) begin seen = 1'b1; n = i; end
      end
      chk({nm, "_latency"}, 32'(n), 32'(NDIG + 1));
      chk({nm, "_busy_cycles"}, 32'(nb), 32'(NDIG + 1));
      chk({nm, "_sum"}, 32'(bus.sum_bcd), 32'(xs));
      chk({nm, "_err"}, 32'(bus.err), 32'(xe));
`ifdef BCD_SUB_EN
      chk({nm, "_neg"}, 32'(bus.neg), 32'(xn));
`else
      if (xn) $display("neg expectation ignored in add-only build");
`endif
   endtask

   initial begin
      int cnt;
      bus.start = 1'b0; bus.first_num = '0; bus.second_num = '0; set_sub(1'b0);
      repeat (3) @(negedge clk);
      chk("reset_sum", 32'(bus.sum_bcd), 32'h0);
      chk("reset_busy", 32'(bus.busy), 32'h0);
      chk("reset_done", 32'(bus.done), 32'h0);
      chk("reset_err", 32'(bus.err), 32'h0);
      rst = 1'b1;
      @(negedge clk);

      run_op("add_123_456", 12'h123, 12'h456, 1'b0, 16'h0579, 1'b0, 1'b0);
      run_op("add_999_999", 12'h999, 12'h999, 1'b0, 16'h1998, 1'b0, 1'b0);
      run_op("add_0a5_001", 12'h0A5, 12'h001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_000_000", 12'h000, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
      run_op("add_501_499", 12'h501, 12'h499, 1'b0, 16'h1000, 1'b0, 1'b0);
`ifdef BCD_SUB_EN
      run_op("sub_100_001", 12'h100, 12'h001, 1'b1, 16'h0099, 1'b0, 1'b0);
      run_op("sub_001_100", 12'h001, 12'h100, 1'b1, 16'h0099, 1'b0, 1'b1);
      run_op("sub_500_500", 12'h500, 12'h500, 1'b1, 16'h0000, 1'b0, 1'b0);
      set_sub(1'b0);
`endif

      // start held high: back-to-back operations
      @(negedge clk);
      bus.first_num = 12'h250; bus.second_num = 12'h250; bus.start = 1'b1;
      @(negedge clk);
      cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.done) cnt++;
         if (i == 9) bus.start = 1'b0;
      end
      chk("b2b_done_count", 32'(cnt), 32'd2);
      chk("b2b_sum", 32'(bus.sum_bcd), 32'h0500);
      repeat (6) @(negedge clk);

      // async reset during the second ADD cycle
      bus.first_num = 12'h777; bus.second_num = 12'h555; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_sum", 32'(bus.sum_bcd), 32'h0);
      chk("midrst_busy", 32'(bus.busy), 32'h0);
      chk("midrst_done", 32'(bus.done), 32'h0);
      chk("midrst_err", 32'(bus.err), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.done) cnt++;
      end
      chk("midrst_no_done", 32'(cnt), 32'd0);
      run_op("post_rst_123_456", 12'h123, 12'h456, 1'b0, 16'h0579, 1'b0, 1'b0);

      // randomized traffic: operands and start change freely, the model latches only accepted starts
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         bus.start      = ($urandom_range(0, 3) == 0);
         bus.first_num  = rnd_bcd();
         bus.second_num = rnd_bcd();
`ifdef BCD_SUB_EN
         bus.sub        = 1'($urandom_range(0, 1));
`endif
      end
      bus.start = 1'b0;
      repeat (8) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
